// File: rtl/spdif_pkg.sv
// Shared S/PDIF definitions: subframe preamble codes and default link dimensions.
package spdif_pkg;

  localparam int SAMPLE_W  = 20;
  localparam int BLOCK_LEN = 192;

  typedef enum logic [1:0] {
    PRE_Z = 2'd0,
    PRE_X = 2'd1,
    PRE_Y = 2'd2
  } preamble_t;

endpackage

// File: rtl/subframe_scheduler.sv
// Alternates left/right sample slots for the S/PDIF frame assembler and tracks the
// channel-status block position, preamble selection and underrun status.
module subframe_scheduler #(
  parameter int SAMPLE_W  = spdif_pkg::SAMPLE_W,
  parameter int BLOCK_LEN = spdif_pkg::BLOCK_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [SAMPLE_W-1:0]  l_din,
  input  logic                 l_valid,
  output logic                 l_ready,
  input  logic [SAMPLE_W-1:0]  r_din,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [BLOCK_LEN-1:0] cs_pattern,
  input  logic                 slot_req,
  output logic [SAMPLE_W-1:0]  frame_din,
  output logic [1:0]           preamble,
  output logic                 cs_bit,
  output logic                 vout,
  output logic [7:0]           frame_counter,
  output logic                 block_done,
  output logic                 underrun
);
  import spdif_pkg::*;

  // state | meaning
  // IDLE  | link stopped, slot requests ignored, frame counter parked at 0
  // LEFT  | next served slot carries the left sample (Z or X preamble)
  // RIGHT | next served slot carries the right sample (Y preamble)
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  localparam logic [7:0] LAST_FRAME = 8'(BLOCK_LEN - 1);

  state_t               state, state_nxt;
  logic                 serve_l, serve_r;
  logic [BLOCK_LEN-1:0] cs_latched;
  preamble_t            preamble_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    serve_l   = 1'b0;
    serve_r   = 1'b0;
    l_ready   = 1'b0;
    r_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = LEFT;
      end
      LEFT: begin
        if (slot_req) begin
          serve_l   = 1'b1;
          l_ready   = l_valid;
          state_nxt = RIGHT;
        end
      end
      RIGHT: begin
        if (slot_req) begin
          serve_r   = 1'b1;
          r_ready   = r_valid;
          state_nxt = enable ? LEFT : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_din     <= '0;
      preamble_q    <= PRE_Z;
      cs_bit        <= 1'b0;
      vout          <= 1'b0;
      frame_counter <= 8'd0;
      block_done    <= 1'b0;
      underrun      <= 1'b0;
      cs_latched    <= '0;
    end else begin
      vout       <= serve_l | serve_r;
      block_done <= 1'b0;
      if (state == IDLE && enable) cs_latched <= cs_pattern;
      if (serve_l) begin
        frame_din  <= l_valid ? l_din : '0;
        preamble_q <= (frame_counter == 8'd0) ? PRE_Z : PRE_X;
        cs_bit     <= cs_latched[frame_counter];
        if (!l_valid) underrun <= 1'b1;
      end
      if (serve_r) begin
        frame_din  <= r_valid ? r_din : '0;
        preamble_q <= PRE_Y;
        cs_bit     <= cs_latched[frame_counter];
        if (!r_valid) underrun <= 1'b1;
        if (frame_counter == LAST_FRAME) begin
          frame_counter <= 8'd0;
          block_done    <= 1'b1;
          cs_latched    <= cs_pattern;
        end else begin
          frame_counter <= frame_counter + 8'd1;
        end
        // stopping always parks the block at its start so the restart opens with Z
        if (!enable) frame_counter <= 8'd0;
      end
    end
  end

  assign preamble = preamble_q;

endmodule

// File: doc/subframe_scheduler.md
SUBFRAME_SCHEDULER -- requirements
Module: subframe_scheduler

Interface
REQ-001 The block SHALL have these parameters: SAMPLE_W, default 20, audio word width; BLOCK_LEN, default 192, frames per channel-status block.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  input  1  single system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  level; 1 = run the link, 0 = stop at the next frame boundary.
- l_din  input  SAMPLE_W  left sample.
- l_valid  input  1  left sample available.
- l_ready  output  1  one-cycle pulse; the left sample is consumed.
- r_din  input  SAMPLE_W  right sample.
- r_valid  input  1  right sample available.
- r_ready  output  1  one-cycle pulse; the right sample is consumed.
- cs_pattern  input  BLOCK_LEN  channel-status bits; bit i belongs to frame i.
- slot_req  input  1  one-cycle pulse from the frame assembler requesting the next subframe word.
- frame_din  output  SAMPLE_W  subframe payload to the assembler.
- preamble  output  2  0 = Z (block start), 1 = X (left), 2 = Y (right).
- cs_bit  output  1  channel-status bit for the current subframe.
- vout  output  1  one-cycle pulse; frame_din, preamble and cs_bit are valid.
- frame_counter  output  8  frame index in the block, 0..BLOCK_LEN-1.
- block_done  output  1  one-cycle pulse after the right subframe of frame BLOCK_LEN-1.
- underrun  output  1  sticky; a sample was missing when its slot was served.

Function
REQ-003 FSM states: IDLE, LEFT, RIGHT.
- IDLE -> LEFT when enable = 1.
- LEFT -> RIGHT when a left slot is served.
- RIGHT -> LEFT when a right slot is served and enable = 1.
- RIGHT -> IDLE when a right slot is served and enable = 0.
REQ-004 In IDLE the block SHALL ignore slot_req, hold vout, l_ready and r_ready at 0, and hold frame_counter at 0.
REQ-005 A slot_req seen in LEFT or RIGHT SHALL be served with exactly one-cycle latency: vout = 1 with frame_din, preamble and cs_bit registered on the cycle after slot_req.
REQ-006 Left slot data: if l_valid = 1 at slot_req, frame_din = l_din and l_ready pulses in the same cycle as slot_req; otherwise frame_din = 0, no l_ready pulse, and underrun is set.
REQ-007 Right slot data: same rule as REQ-006 using r_din, r_valid and r_ready.
REQ-008 preamble SHALL be Z for the left slot when frame_counter = 0, X for every other left slot, and Y for every right slot.
REQ-009 cs_bit SHALL be cs_latched[frame_counter] for both subframes of a frame.
REQ-010 frame_counter SHALL increment by one after each right slot is served.
REQ-011 frame_counter SHALL wrap from BLOCK_LEN-1 to 0; block_done SHALL pulse in the same cycle as that right slot's vout.
REQ-012 cs_latched SHALL load cs_pattern on the IDLE->LEFT transition and at every wrap; changes to cs_pattern mid-block SHALL have no effect until the next load.
REQ-013 If enable falls mid-frame, the block SHALL finish the current right slot and then enter IDLE, leaving frame_counter at 0.
REQ-014 A slot_req arriving while vout is still asserted from the previous slot SHALL be served normally on the next cycle.
REQ-015 underrun SHALL clear only on rst.

Reset
REQ-016 On rst assertion the block SHALL immediately enter IDLE and force these outputs to 0: frame_din, preamble, cs_bit, vout, l_ready, r_ready, frame_counter, block_done, underrun.
REQ-017 A reset in mid-block SHALL discard the in-progress frame; the first frame after release SHALL carry preamble Z.

Structure
REQ-018 The shared package spdif_pkg SHALL hold the preamble enum (Z, X, Y), SAMPLE_W and BLOCK_LEN.
REQ-019 The FSM state enum SHALL be local to the module.
REQ-020 The block SHALL be a single module with no sub-modules; its counter and state are too small to justify splitting.

Verification
REQ-021 Basic sequence: enable = 1, both valids held high, l_din = 20'h12345, r_din = 20'h6789A, slot_req every 64 cycles -> first outputs Z/12345 then Y/6789A; from frame 1, X/Y alternation.
REQ-022 Block wrap: run 192 frames -> frame_counter goes 191 -> 0, block_done pulses once, and the next left preamble is Z.
REQ-023 Underrun: l_valid = 0 at one left slot_req -> frame_din = 0, no l_ready pulse, underrun goes to 1 and stays 1.
REQ-024 Channel status: cs_pattern = 192'h1 -> cs_bit = 1 only in frame 0; changing cs_pattern mid-block has no effect until the next block.
REQ-025 Stop: enable drops during a left slot -> the right slot is still emitted, then the FSM is in IDLE and later slot_req pulses produce no vout.
REQ-026 Reset mid-block: rst asserted at frame 50 -> all outputs go to 0 immediately; after release and enable, the first preamble is Z.
